// File: rtl/bwt_pkg.sv
// Shared definitions for the BWT backward-search controller.
// Holds the base encodings, the controller state enum, the address/value
// widths and a helper that picks one C-table entry out of the packed table.
package bwt_pkg;

    localparam int TAGT_NUM    = 64;    // max query length in bases
    localparam int TAGT_LENGTH = 6;     // target memory address width
    localparam int REF_NUM     = 1024;  // suffix-array rows
    localparam int REF_LENGTH  = 10;    // reference address / Occ / C width

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEL   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // C[base] from the packed table: A in the low slice, T in the high slice.
    function automatic logic [REF_LENGTH-1:0] cSel(
        input logic [4*REF_LENGTH-1:0] cTab,
        input logic [1:0]              base
    );
        logic [REF_LENGTH-1:0] r;
        case (base)
            BASE_A:  r = cTab[1*REF_LENGTH-1:0*REF_LENGTH];
            BASE_C:  r = cTab[2*REF_LENGTH-1:1*REF_LENGTH];
            BASE_G:  r = cTab[3*REF_LENGTH-1:2*REF_LENGTH];
            BASE_T:  r = cTab[4*REF_LENGTH-1:3*REF_LENGTH];
            default: r = {REF_LENGTH{1'b0}};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bwt_interval_update.sv
// One backward-search narrowing step (pure combinational).
// Ports:
//   cVal    - C[a] for the base being processed
//   occLo   - raw Occ(a, low-1) from the selector
//   occHi   - Occ(a, high) from the selector
//   loZero  - low bound was 0, so Occ(a, -1) is taken as 0
//   newLow  - C[a] + occ_lo, truncated to REF_LENGTH bits
//   newHigh - C[a] + occ_hi - 1, truncated to REF_LENGTH bits
//   empty   - occ_hi == occ_lo, the narrowed interval holds no rows
module bwt_interval_update
    import bwt_pkg::*;
(
    input  logic [REF_LENGTH-1:0] cVal,
    input  logic [REF_LENGTH-1:0] occLo,
    input  logic [REF_LENGTH-1:0] occHi,
    input  logic                  loZero,
    output logic [REF_LENGTH-1:0] newLow,
    output logic [REF_LENGTH-1:0] newHigh,
    output logic                  empty
);

    localparam logic [REF_LENGTH:0] WIDE_ONE = {{REF_LENGTH{1'b0}}, 1'b1};

    logic [REF_LENGTH-1:0] occLoEff_s;
    logic [REF_LENGTH:0]   lowSum_s;
    logic [REF_LENGTH:0]   highSum_s;

    // Sums are formed one bit wider so the carry is dropped explicitly.
    always_comb begin
        if (loZero) begin
            occLoEff_s = {REF_LENGTH{1'b0}};
        end else begin
            occLoEff_s = occLo;
        end
        lowSum_s  = {1'b0, cVal} + {1'b0, occLoEff_s};
        highSum_s = {1'b0, cVal} + {1'b0, occHi} - WIDE_ONE;
        newLow    = lowSum_s[REF_LENGTH-1:0];
        newHigh   = highSum_s[REF_LENGTH-1:0];
        empty     = (occHi == occLoEff_s);
    end

endmodule

// File: rtl/bwt_search_ctrl.sv
// Backward-search controller: walks the query from its last base to its
// first, narrowing the suffix-array interval [low, high] via the Occ
// selector, three cycles per base (FETCH target base, SEL issue Occ read,
// WAIT consume Occ results).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, q_len        - one-cycle start pulse and query length (IDLE only)
//   c_tab               - packed C table, C[A] in the low slice
//   t_en, t_addr, t_data- target memory read port (data one cycle later)
//   sig                 - registered base select to the Occ selector
//   rEn, rAddr0, rAddr1 - Occ read port for the low-1 and high bounds
//   data0, data1        - Occ results, valid the cycle after rEn
//   busy, done          - search in progress / one-cycle completion pulse
//   found, res_low/high - outcome and final interval, held until next start
module bwt_search_ctrl
    import bwt_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [TAGT_LENGTH:0]    q_len,
    input  logic [4*REF_LENGTH-1:0] c_tab,
    output logic                    t_en,
    output logic [TAGT_LENGTH-1:0]  t_addr,
    input  logic [1:0]              t_data,
    output logic [1:0]              sig,
    output logic                    rEn,
    output logic [REF_LENGTH-1:0]   rAddr0,
    output logic [REF_LENGTH-1:0]   rAddr1,
    input  logic [REF_LENGTH-1:0]   data0,
    input  logic [REF_LENGTH-1:0]   data1,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [REF_LENGTH-1:0]   res_low,
    output logic [REF_LENGTH-1:0]   res_high
);

    localparam logic [REF_LENGTH-1:0]  REF_ZERO = {REF_LENGTH{1'b0}};
    localparam logic [REF_LENGTH-1:0]  REF_ONE  = {{(REF_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [REF_LENGTH-1:0]  REF_LAST = REF_LENGTH'(REF_NUM - 1);
    localparam logic [TAGT_LENGTH-1:0] IDX_ZERO = {TAGT_LENGTH{1'b0}};
    localparam logic [TAGT_LENGTH-1:0] IDX_ONE  = {{(TAGT_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [TAGT_LENGTH:0]   QLEN_ZERO = {(TAGT_LENGTH+1){1'b0}};

    state_e                  stateR;
    state_e                  nextState_s;
    logic [REF_LENGTH-1:0]   lowR;
    logic [REF_LENGTH-1:0]   highR;
    logic [TAGT_LENGTH-1:0]  idxR;
    logic                    loZeroR;
    logic [1:0]              sigR;
    logic                    busyR;
    logic                    doneR;
    logic                    foundR;
    logic [REF_LENGTH-1:0]   resLowR;
    logic [REF_LENGTH-1:0]   resHighR;

    logic [REF_LENGTH-1:0]   cVal_s;
    logic [REF_LENGTH-1:0]   newLow_s;
    logic [REF_LENGTH-1:0]   newHigh_s;
    logic                    empty_s;

    // C entry for the base latched in SEL; sigR is stable through WAIT.
    always_comb begin
        cVal_s = cSel(c_tab, sigR);
    end

    bwt_interval_update uUpdate (
        .cVal    (cVal_s),
        .occLo   (data0),
        .occHi   (data1),
        .loZero  (loZeroR),
        .newLow  (newLow_s),
        .newHigh (newHigh_s),
        .empty   (empty_s)
    );

    // Next-state logic.
    always_comb begin
        nextState_s = stateR;
        case (stateR)
            IDLE: begin
                if (start) begin
                    if (q_len == QLEN_ZERO) begin
                        nextState_s = DONE;
                    end else begin
                        nextState_s = FETCH;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            FETCH: nextState_s = SEL;
            SEL:   nextState_s = WAIT;
            WAIT: begin
                if (empty_s || (idxR == IDX_ZERO)) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = FETCH;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Memory-port strobes decode straight from the state register so the two
    // enables are mutually exclusive; addresses come from registers only.
    always_comb begin
        t_en   = (stateR == FETCH);
        rEn    = (stateR == SEL);
        t_addr = idxR;
        if (lowR == REF_ZERO) begin
            rAddr0 = REF_ZERO;
        end else begin
            rAddr0 = lowR - REF_ONE;
        end
        rAddr1 = highR;
    end

    // State, interval and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR   <= IDLE;
            lowR     <= REF_ZERO;
            highR    <= REF_ZERO;
            idxR     <= IDX_ZERO;
            loZeroR  <= 1'b0;
            sigR     <= 2'b00;
            busyR    <= 1'b0;
            doneR    <= 1'b0;
            foundR   <= 1'b0;
            resLowR  <= REF_ZERO;
            resHighR <= REF_ZERO;
        end else begin
            stateR <= nextState_s;
            doneR  <= (nextState_s == DONE);
            busyR  <= (nextState_s != IDLE);
            case (stateR)
                IDLE: begin
                    if (start) begin
                        lowR  <= REF_ZERO;
                        highR <= REF_LAST;
                        if (q_len == QLEN_ZERO) begin
                            // Empty query matches every row.
                            foundR   <= 1'b1;
                            resLowR  <= REF_ZERO;
                            resHighR <= REF_LAST;
                        end else begin
                            idxR     <= q_len[TAGT_LENGTH-1:0] - IDX_ONE;
                            foundR   <= 1'b0;
                            resLowR  <= REF_ZERO;
                            resHighR <= REF_ZERO;
                        end
                    end
                end
                SEL: begin
                    sigR    <= t_data;
                    loZeroR <= (lowR == REF_ZERO);
                end
                WAIT: begin
                    if (empty_s) begin
                        // Report the last non-empty interval.
                        foundR   <= 1'b0;
                        resLowR  <= lowR;
                        resHighR <= highR;
                    end else begin
                        lowR  <= newLow_s;
                        highR <= newHigh_s;
                        if (idxR == IDX_ZERO) begin
                            foundR   <= 1'b1;
                            resLowR  <= newLow_s;
                            resHighR <= newHigh_s;
                        end else begin
                            idxR <= idxR - IDX_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sig      = sigR;
    assign busy     = busyR;
    assign done     = doneR;
    assign found    = foundR;
    assign res_low  = resLowR;
    assign res_high = resHighR;

endmodule

// File: tb/tb_bwt_search_ctrl.sv
// Self-checking bench for bwt_search_ctrl. The bench plays target memory and
// Occ selector (tables built from a random BWT string) and predicts each
// search with a plain backward-search model over those tables.
module tb_bwt_search_ctrl;
    import bwt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  q_len;
    logic [39:0] c_tab;
    logic        t_en;
    logic [5:0]  t_addr;
    logic [1:0]  t_data = 2'b00;
    logic [1:0]  sig;
    logic        rEn;
    logic [9:0]  rAddr0, rAddr1;
    logic [9:0]  data0, data1;
    logic        busy, done, found;
    logic [9:0]  res_low, res_high;

    int          nVec  = 0;
    int          nFail = 0;

    int          bwt    [REF_NUM];
    int          occTab [4][REF_NUM];
    int          cArr   [4];
    logic [1:0]  tgt    [TAGT_NUM];
    logic [9:0]  a0q = 10'd0;
    logic [9:0]  a1q = 10'd0;

    bwt_search_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q_len(q_len), .c_tab(c_tab),
        .t_en(t_en), .t_addr(t_addr), .t_data(t_data), .sig(sig), .rEn(rEn),
        .rAddr0(rAddr0), .rAddr1(rAddr1), .data0(data0), .data1(data1),
        .busy(busy), .done(done), .found(found),
        .res_low(res_low), .res_high(res_high)
    );

    always #5 clk = ~clk;

    // Target memory: one-cycle read latency.
    always @(posedge clk) begin
        if (t_en) t_data <= tgt[t_addr];
    end

    // Occ selector: addresses registered on rEn, base mux combinational on sig.
    always @(posedge clk) begin
        if (rEn) begin
            a0q <= rAddr0;
            a1q <= rAddr1;
        end
    end

    always_comb begin
        data0 = 10'(occTab[sig][a0q]);
        data1 = 10'(occTab[sig][a1q]);
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outVec();
        return {11'd0, t_en, rEn, sig, busy, done, found, t_addr,
                rAddr0, rAddr1, res_low, res_high};
    endfunction

    task automatic applyC();
        c_tab = {10'(cArr[3]), 10'(cArr[2]), 10'(cArr[1]), 10'(cArr[0])};
    endtask

    // Random BWT with one '$' (code 4), or '$' followed by all T.
    task automatic buildTables(input bit allT);
        int cnt[4];
        for (int a = 0; a < 4; a++) cnt[a] = 0;
        for (int i = 0; i < REF_NUM; i++) begin
            if (allT) bwt[i] = (i == 0) ? 4 : 3;
            else      bwt[i] = $urandom_range(0, 3);
        end
        if (!allT) bwt[$urandom_range(0, REF_NUM-1)] = 4;
        for (int i = 0; i < REF_NUM; i++) begin
            if (bwt[i] < 4) cnt[bwt[i]]++;
            for (int a = 0; a < 4; a++) occTab[a][i] = cnt[a];
        end
        cArr[0] = 1;
        for (int a = 1; a < 4; a++) cArr[a] = cArr[a-1] + cnt[a-1];
        applyC();
    endtask

    // Backward search over the bench tables; steps = bases examined.
    task automatic refSearch(input int len, output bit f, output int lo, output int hi,
                             output int steps);
        int l = 0;
        int h = REF_NUM - 1;
        int a, ol, oh;
        f = 1'b1;
        steps = 0;
        for (int i = len - 1; i >= 0; i--) begin
            a = int'(tgt[i]);
            steps++;
            ol = (l == 0) ? 0 : occTab[a][l-1];
            oh = occTab[a][h];
            if (ol == oh) begin
                f = 1'b0;
                break;
            end
            l = (cArr[a] + ol) % REF_NUM;
            h = (cArr[a] + oh - 1) % REF_NUM;
        end
        lo = l;
        hi = h;
    endtask

    task automatic runSearch(input int len, input bit dbl);
        bit eF;
        int eLo, eHi, eSteps;
        int cyc, fetches, rens, sigIdx;
        bit sawDone, sigPend;
        refSearch(len, eF, eLo, eHi, eSteps);
        @(negedge clk);
        start = 1'b1;
        q_len = 7'(len);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; fetches = 0; rens = 0; sigIdx = 0;
        sawDone = 1'b0; sigPend = 1'b0;
        while (!sawDone && cyc < 400) begin
            if (sigPend) begin
                checkVal("sig", 64'(sig), 64'(tgt[sigIdx]));
                sigPend = 1'b0;
            end
            if (t_en) begin
                checkVal("t_addr", 64'(t_addr), 64'(len - 1 - fetches));
                fetches++;
            end
            if (rEn) begin
                rens++;
                sigPend = 1'b1;
                sigIdx = len - rens;
            end
            checkVal("excl", 64'(t_en & rEn), 64'd0);
            if (cyc == 1 && len > 0) checkVal("busy", 64'(busy), 64'd1);
            if (dbl && cyc == 2) begin
                start = 1'b1;
                q_len = 7'($urandom_range(0, 64));
            end else begin
                start = 1'b0;
            end
            if (done) sawDone = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        checkVal("done_cyc", 64'(cyc), 64'(3 * eSteps + 1));
        checkVal("found", 64'(found), 64'(eF));
        checkVal("res_low", 64'(res_low), 64'(eLo));
        checkVal("res_high", 64'(res_high), 64'(eHi));
        checkVal("fetches", 64'(fetches), 64'(eSteps));
        checkVal("occ_reads", 64'(rens), 64'(eSteps));
        @(negedge clk);
        checkVal("done_pulse", 64'(done), 64'd0);
        checkVal("busy_end", 64'(busy), 64'd0);
    endtask

    task automatic resetMid();
        for (int i = 0; i < 4; i++) tgt[i] = 2'($urandom_range(0, 3));
        @(negedge clk);
        start = 1'b1;
        q_len = 7'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkVal("in_wait", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkVal("mid_rst", outVec(), 64'd0);
        repeat (2) begin
            @(negedge clk);
            checkVal("rst_hold", outVec(), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("post_rst", outVec(), 64'd0);
    endtask

    initial begin
        int len;
        rst_n = 1'b0;
        start = 1'b0;
        q_len = 7'd0;
        for (int i = 0; i < TAGT_NUM; i++) tgt[i] = 2'b00;
        buildTables(1'b0);
        repeat (3) @(negedge clk);
        checkVal("rst_state", outVec(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("idle_state", outVec(), 64'd0);

        // Single base A; Occ_A(0) is nonzero so lo_zero forcing matters.
        cArr[0] = 1;
        applyC();
        occTab[0][1023] = 300;
        occTab[0][0] = 77;
        tgt[0] = BASE_A;
        runSearch(1, 1'b0);
        checkVal("one_low", 64'(res_low), 64'd1);
        checkVal("one_high", 64'(res_high), 64'd300);

        // Two bases {C, G}: G then C.
        cArr[1] = 301;
        cArr[2] = 600;
        applyC();
        occTab[2][1023] = 4;
        occTab[1][599] = 2;
        occTab[1][603] = 4;
        tgt[0] = BASE_C;
        tgt[1] = BASE_G;
        runSearch(2, 1'b0);
        checkVal("two_low", 64'(res_low), 64'd303);
        checkVal("two_high", 64'(res_high), 64'd304);

        // Empty interval on the second step: no third fetch.
        occTab[1][599] = 7;
        occTab[1][603] = 7;
        tgt[2] = BASE_G;
        tgt[1] = BASE_C;
        tgt[2] = BASE_G;
        tgt[0] = BASE_A;
        tgt[1] = BASE_C;
        tgt[2] = BASE_G;
        runSearch(3, 1'b0);
        checkVal("miss_found", 64'(found), 64'd0);
        checkVal("miss_low", 64'(res_low), 64'd600);
        checkVal("miss_high", 64'(res_high), 64'd603);

        // Empty query.
        runSearch(0, 1'b0);
        checkVal("q0_found", 64'(found), 64'd1);
        checkVal("q0_high", 64'(res_high), 64'd1023);

        // Restart pulse while busy, then reset during WAIT, then a clean run.
        buildTables(1'b0);
        for (int i = 0; i < TAGT_NUM; i++) tgt[i] = 2'($urandom_range(0, 3));
        runSearch(3, 1'b1);
        resetMid();
        runSearch(2, 1'b0);

        // Full-length query of T over an all-T BWT.
        buildTables(1'b1);
        for (int i = 0; i < TAGT_NUM; i++) tgt[i] = BASE_T;
        runSearch(64, 1'b0);
        checkVal("allT_found", 64'(found), 64'd1);
        checkVal("allT_low", 64'(res_low), 64'd1);
        checkVal("allT_high", 64'(res_high), 64'd1023);

        // Randomized searches.
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 0) buildTables(1'b0);
            for (int i = 0; i < TAGT_NUM; i++) tgt[i] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(9, 64);
            else                           len = $urandom_range(1, 8);
            runSearch(len, (n % 7 == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
